// File: rtl/cosim_pkg.sv
// rtl/cosim_pkg.sv - shared types and constants for the cosim commit scoreboard
package cosim_pkg;

    localparam int REC_XLEN = 64;

    localparam int MM_PC    = 0;
    localparam int MM_INSTR = 1;
    localparam int MM_RD    = 2;
    localparam int MM_DATA  = 3;

    typedef struct packed {
        logic [REC_XLEN-1:0] pc;
        logic [31:0]         instr;
        logic [4:0]          rd;
        logic                wen;
        logic [REC_XLEN-1:0] data;
        logic                excep;
    } commit_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HALTED = 2'd2
    } sb_state_t;

    // Widen a w-bit value held in the low bits of v to REC_XLEN by sign extension.
    function automatic logic [REC_XLEN-1:0] sext(input logic [REC_XLEN-1:0] v, input int w);
        logic [REC_XLEN-1:0] hi_mask;
        logic                sign;
        hi_mask = {REC_XLEN{1'b1}} << w;
        sign    = v[6'(w - 1)];
        return sign ? (v | hi_mask) : (v & ~hi_mask);
    endfunction

endpackage

// File: rtl/cosim_commit_fifo.sv
// rtl/cosim_commit_fifo.sv - LANES-write, single-read circular buffer of commit records
module cosim_commit_fifo
    import cosim_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0]        wr_valid,
    input  commit_rec_t [LANES-1:0] wr_rec,
    input  logic                    rd_en,
    output commit_rec_t             rd_rec,
    output logic [PW-1:0]           count
);

    commit_rec_t   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wr_cnt;
    logic [AW-1:0] slot [LANES];

    // Compact the valid lanes onto consecutive slots starting at the write pointer.
    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = wptr[AW-1:0] + wr_cnt[AW-1:0];
            if (wr_valid[i]) begin
                wr_cnt = wr_cnt + PW'(1);
            end
        end
    end

    // Storage write; entries need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_valid[i]) begin
                mem[slot[i]] <= wr_rec[i];
            end
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + wr_cnt;
            if (rd_en) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    assign count  = wptr - rptr;
    assign rd_rec = mem[rptr[AW-1:0]];

endmodule

// File: rtl/cosim_commit_scoreboard.sv
// rtl/cosim_commit_scoreboard.sv - multi-lane commit vs reference scoreboard; optional COSIM_HALT_ON_MISMATCH_EN
module cosim_commit_scoreboard
    import cosim_pkg::*;
#(
    parameter int          LANES    = 2,
    parameter int          XLEN     = 64,
    parameter int          DEPTH    = 16,
    parameter logic [63:0] START_PC = 64'h8000_0000,
    parameter int          TIMEOUT  = 1024,
    parameter int          CNTW     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           hart_id,
    input  logic [LANES-1:0]      cmt_valid_i,
    input  logic [LANES*XLEN-1:0] cmt_pc_i,
    input  logic [LANES*32-1:0]   cmt_instr_i,
    input  logic [LANES*5-1:0]    cmt_rd_i,
    input  logic [LANES-1:0]      cmt_wen_i,
    input  logic [LANES*XLEN-1:0] cmt_data_i,
    input  logic [LANES-1:0]      cmt_excep_i,
    input  logic                  ref_valid_i,
    output logic                  ref_ready_o,
    input  logic [XLEN-1:0]       ref_pc_i,
    input  logic [31:0]           ref_instr_i,
    input  logic [4:0]            ref_rd_i,
    input  logic [XLEN-1:0]       ref_data_i,
    output logic                  active_o,
    output logic                  mismatch_o,
    output logic [3:0]            mismatch_kind_o,
    output logic [CNTW-1:0]       err_count_o,
    output logic [CNTW-1:0]       cmp_count_o,
    output logic                  overflow_o,
    output logic                  timeout_o,
    output logic                  halted_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    sb_state_t               state;
    sb_state_t               state_nx;
    commit_rec_t [LANES-1:0] lane_rec;
    commit_rec_t             head;
    logic [LANES-1:0]        start_hit;
    logic [LANES-1:0]        lane_mask;
    logic [LANES-1:0]        wr_valid;
    logic [CW-1:0]           occ;
    logic [CW-1:0]           push_cnt;
    logic [CW-1:0]           free_cnt;
    logic                    found;
    logic                    ovf_now;
    logic                    hs;
    logic [3:0]              kind_now;
    logic [REC_XLEN-1:0]     raw_pc;
    logic [REC_XLEN-1:0]     raw_data;
    logic [REC_XLEN-1:0]     ref_raw_pc;
    logic [REC_XLEN-1:0]     ref_raw_data;
    logic [REC_XLEN-1:0]     ref_pc_x;
    logic [REC_XLEN-1:0]     ref_data_x;
    logic [TW-1:0]           tmo_cnt;
    logic [TW-1:0]           tmo_nx;
    logic                    unused_hart;

    assign unused_hart = ^hart_id;

    // Unpack the lane buses into records, widening PC and data to the record width.
    always_comb begin
        lane_rec = '0;
        raw_pc   = '0;
        raw_data = '0;
        for (int i = 0; i < LANES; i++) begin
            raw_pc               = '0;
            raw_data             = '0;
            raw_pc[XLEN-1:0]     = cmt_pc_i[i*XLEN +: XLEN];
            raw_data[XLEN-1:0]   = cmt_data_i[i*XLEN +: XLEN];
            lane_rec[i].pc       = sext(raw_pc, XLEN);
            lane_rec[i].instr    = cmt_instr_i[i*32 +: 32];
            lane_rec[i].rd       = cmt_rd_i[i*5 +: 5];
            lane_rec[i].wen      = cmt_wen_i[i];
            lane_rec[i].data     = sext(raw_data, XLEN);
            lane_rec[i].excep    = cmt_excep_i[i];
        end
    end

    // Gating: before activation only the first START_PC lane and the lanes above it pass.
    always_comb begin
        start_hit = '0;
        lane_mask = '0;
        push_cnt  = '0;
        found     = (state == ST_ACTIVE);
        for (int i = 0; i < LANES; i++) begin
            start_hit[i] = cmt_valid_i[i] && (cmt_pc_i[i*XLEN +: XLEN] == START_PC[XLEN-1:0]);
            if (start_hit[i]) begin
                found = 1'b1;
            end
            lane_mask[i] = cmt_valid_i[i] && found && (state != ST_HALTED);
            push_cnt     = push_cnt + CW'(lane_mask[i]);
        end
        free_cnt = CW'(DEPTH) - occ;
        ovf_now  = (push_cnt > free_cnt);
        wr_valid = ovf_now ? '0 : lane_mask;
    end

    cosim_commit_fifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_rec   (lane_rec),
        .rd_en    (hs),
        .rd_rec   (head),
        .count    (occ)
    );

    assign active_o    = (state != ST_IDLE);
    assign ref_ready_o = (state == ST_ACTIVE) && (occ != '0);
    assign hs          = ref_valid_i && ref_ready_o;

`ifdef COSIM_HALT_ON_MISMATCH_EN
    assign halted_o = (state == ST_HALTED);
`else
    assign halted_o = 1'b0;
`endif

    // Compare the FIFO head with the reference record; traps skip every field.
    always_comb begin
        ref_raw_pc               = '0;
        ref_raw_data             = '0;
        ref_raw_pc[XLEN-1:0]     = ref_pc_i;
        ref_raw_data[XLEN-1:0]   = ref_data_i;
        ref_pc_x                 = sext(ref_raw_pc, XLEN);
        ref_data_x               = sext(ref_raw_data, XLEN);
        kind_now                 = '0;
        if (!head.excep) begin
            kind_now[MM_PC] = (head.pc != ref_pc_x);
            if (head.instr[1:0] != 2'b11) begin
                kind_now[MM_INSTR] = (head.instr[15:0] != ref_instr_i[15:0]);
            end else begin
                kind_now[MM_INSTR] = (head.instr != ref_instr_i);
            end
            if (head.wen && (head.rd != 5'd0)) begin
                kind_now[MM_RD]   = (head.rd != ref_rd_i);
                kind_now[MM_DATA] = (head.data != ref_data_x);
            end
        end
    end

    // Mode control: inactive until START_PC commits, optionally frozen by the first mismatch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (|start_hit) begin
                    state_nx = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
`ifdef COSIM_HALT_ON_MISMATCH_EN
                if (hs && (kind_now != '0)) begin
                    state_nx = ST_HALTED;
                end
`else
                state_nx = ST_ACTIVE;
`endif
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Mode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Starvation timer: counts waiting cycles with a non-empty FIFO, frozen while halted.
    always_comb begin
        tmo_nx = tmo_cnt;
        if (state == ST_HALTED) begin
            tmo_nx = tmo_cnt;
        end else if ((occ == '0) || hs) begin
            tmo_nx = '0;
        end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_nx = tmo_cnt + TW'(1);
        end
    end

    // Registered results: mismatch pulse, saturating counters and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_o      <= 1'b0;
            mismatch_kind_o <= '0;
            err_count_o     <= '0;
            cmp_count_o     <= '0;
            overflow_o      <= 1'b0;
            timeout_o       <= 1'b0;
            tmo_cnt         <= '0;
        end else begin
            mismatch_o      <= hs && (kind_now != '0);
            mismatch_kind_o <= hs ? kind_now : '0;
            if (hs && (cmp_count_o != '1)) begin
                cmp_count_o <= cmp_count_o + CNTW'(1);
            end
            if (hs && (kind_now != '0) && (err_count_o != '1)) begin
                err_count_o <= err_count_o + CNTW'(1);
            end
            if (ovf_now) begin
                overflow_o <= 1'b1;
            end
            tmo_cnt <= tmo_nx;
            if (tmo_nx == TW'(TIMEOUT)) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cosim_commit_scoreboard.md
# cosim_commit_scoreboard

Parametrised, synthesizable successor to the single-lane cosim scoreboard. It accepts up to LANES in-order commits per cycle from a core and buffers them in a circular FIFO. Each buffered commit is matched against one reference-model record (Spike, stepped by the DPI driver) per valid/ready handshake. PC, instruction, destination register and write data are compared, and the block reports mismatches, counts, overflow and a reference-starvation timeout. It sits beside each hart's commit stage in the MEEP cosim bench.

## Interface
- LANES, 2: commit lanes per cycle (1..4)
- XLEN, 64: PC/data width
- DEPTH, 16: FIFO entries; power of two, ≥ 2*LANES
- START_PC, 64'h8000_0000: comparison starts at the first commit with this PC
- TIMEOUT, 1024: cycles a non-empty FIFO may wait for a reference record
- CNTW, 32: counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hart_id  in  64  hart number, used for reporting only
- cmt_valid_i  in  LANES  per-lane commit valid; lane 0 is oldest
- cmt_pc_i  in  LANES*XLEN  commit PC; sign-extended internally if narrower
- cmt_instr_i  in  LANES*32  instruction bits
- cmt_rd_i  in  LANES*5  destination x-register
- cmt_wen_i  in  LANES  x-register write enable
- cmt_data_i  in  LANES*XLEN  write data
- cmt_excep_i  in  LANES  commit is a trap
- ref_valid_i  in  1  reference record valid
- ref_ready_o  out  1  block accepts reference record
- ref_pc_i / ref_instr_i / ref_rd_i / ref_data_i  in  XLEN/32/5/XLEN  reference record
- active_o  out  1  comparison enabled
- mismatch_o  out  1  one-cycle pulse per mismatching record
- mismatch_kind_o  out  4  {data, rd, instr, pc}; valid with mismatch_o
- err_count_o  out  CNTW  mismatching records, saturating
- cmp_count_o  out  CNTW  compared records, saturating
- overflow_o  out  1  sticky: commits dropped for lack of space
- timeout_o  out  1  sticky: reference starvation
- halted_o  out  1  see Configuration

## Operation
- Reset values: all outputs 0; FIFO empty; active_o 0.
- Gating: while inactive, valid lanes with PC ≠ START_PC are discarded.
  - The lowest lane with PC == START_PC sets active_o, effective the next cycle.
  - That lane and all higher valid lanes are enqueued in the same cycle.
- Enqueue: valid lanes are compacted in ascending lane order.
  - Free space is computed from occupancy at the start of the cycle. A same-cycle pop does not add space.
  - If the valid-lane count exceeds free space, no lane of that cycle is written and overflow_o is set.
- ref_ready_o = active_o & FIFO non-empty (registered occupancy) & !halted_o.
  - An entry enqueued into an empty FIFO is visible the following cycle.
- A handshake (ref_valid_i & ref_ready_o) pops the head and compares it with the reference record:
  - pc: XLEN compare.
  - instr: if head instr[1:0] ≠ 2'b11 (compressed), compare bits [15:0] only; otherwise compare all 32 bits.
  - rd and data: compared only when head wen = 1 and rd ≠ 0.
  - If head excep = 1, all comparisons are skipped. The record still counts in cmp_count_o.
- Counters saturate at 2^CNTW−1.
- Timeout counter:
  - Increments each cycle the FIFO is non-empty with no handshake.
  - Clears on a handshake or when the FIFO is empty.
  - Reaching TIMEOUT sets timeout_o.
- Sticky flags clear only on reset.
- Reset mid-operation discards all FIFO contents and returns to the inactive state.

## Timing
- Commit to earliest pop: 1 cycle.
- Handshake to mismatch_o/mismatch_kind_o and counter update: 1 cycle (registered).
- Throughput: one comparison per cycle; enqueue up to LANES per cycle.
- Simultaneous enqueue and pop in one cycle is legal. Occupancy updates by (pushed − popped).
- Pointers wrap modulo DEPTH. Full/empty use an extra pointer bit.

## Configuration
- COSIM_HALT_ON_MISMATCH_EN defined:
  - The first mismatch sets halted_o in the same cycle as mismatch_o.
  - While halted, ref_ready_o is forced 0 and enqueue stops. FIFO contents are frozen for inspection.
  - The timeout counter is held.
- Undefined: halted_o is tied 0 and comparison continues after mismatches.

## Structure
- Package cosim_pkg holds:
  - commit_rec_t {pc, instr, rd, wen, data, excep}
  - mismatch bit-index constants MM_PC=0, MM_INSTR=1, MM_RD=2, MM_DATA=3
- Sub-module cosim_commit_fifo: LANES-write, single-read circular buffer of commit_rec_t, with occupancy output.
- Top level holds gating, comparator, counters, timeout and the halt logic.

## Test plan
- Gating: lane0 PC 0x1000 then lane0 PC 0x8000_0000 → first discarded; active_o=1 next cycle; one entry queued.
- Dual-lane match: 10 cycles with both lanes valid and matching reference records → cmp_count_o=20, err_count_o=0, mismatch_o never set.
- Compressed instruction: RTL instr 0xDEAD_4501, reference 0x0000_4501 → no mismatch. RTL 0x0000_4503 vs reference 0x0000_4513 → mismatch_kind_o=4'b0010.
- Data/exception: wen=1, rd=5, data 0x10 vs reference 0x11 → kind 4'b1000. Same values with excep=1 → no mismatch, cmp_count_o increments. rd=0 with differing data → no mismatch.
- Overflow: DEPTH=4, LANES=2, reference held invalid, 3 cycles of 2 valid lanes → overflow_o=1, occupancy stays 4.
- Timeout and halt: TIMEOUT=8, one entry queued, reference idle → timeout_o=1 after 8 cycles. With COSIM_HALT_ON_MISMATCH_EN, a PC mismatch → halted_o=1, ref_ready_o=0 thereafter, err_count_o=1.
